freq_bcd_conv: RTL and testbench



---
 rtl/freq_bcd_conv.sv | 142 ++++++++++++++
 tb/tb_freq_bcd_conv.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_bcd_conv.sv
// Sequential double-dabble converter: binary frequency value to packed BCD, with a significant-digit count and overflow flag.
// Define FREQ_BCD_LEADING_ZERO_BLANK_EN to replace leading zero digits with the 4'hF blank code.
module freq_bcd_conv #(
    parameter int unsigned BIN_WIDTH = 30,
    parameter int unsigned DIGITS    = 10
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [3:0]            digit_cnt,
    output logic                  ovf
);

    localparam int unsigned CW = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        FINISH
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BIN_WIDTH-1:0] shift_reg;
    logic [4*DIGITS-1:0]  acc;
    logic [4*DIGITS-1:0]  acc_adj;
    logic [4*DIGITS-1:0]  acc_shift;
    logic [4*DIGITS-1:0]  result;
    logic [3:0]           cnt_result;
    logic [CW-1:0]        bit_cnt;
    logic                 ovf_int;
    logic                 ovf_shift;
    logic                 last_shift;

    // Add-3 correction and the one-bit shift for the current CONV cycle
    always_comb begin
        acc_adj = acc;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        acc_shift  = {acc_adj[4*DIGITS-2:0], shift_reg[BIN_WIDTH-1]};
        ovf_shift  = ovf_int | acc_adj[4*DIGITS-1];
        last_shift = (bit_cnt == CW'(BIN_WIDTH - 1));
    end

    // Final result is formed from the post-shift value so it lands in the done cycle
    always_comb begin
        cnt_result = 4'd1;
        for (int unsigned d = 1; d < DIGITS; d++) begin
            if (acc_shift[4*d +: 4] != 4'd0) begin
                cnt_result = 4'(d + 1);
            end
        end
        result = acc_shift;
`ifdef FREQ_BCD_LEADING_ZERO_BLANK_EN
        for (int unsigned d = 1; d < DIGITS; d++) begin
            if (d >= 32'(cnt_result)) begin
                result[4*d +: 4] = 4'hF;
            end
        end
`endif
        if (ovf_shift) begin
            result     = {DIGITS{4'h9}};
            cnt_result = 4'(DIGITS);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (last_shift) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            shift_reg <= '0;
            acc       <= '0;
            bit_cnt   <= '0;
            ovf_int   <= 1'b0;
            bcd_out   <= '0;
            digit_cnt <= 4'd1;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin_in;
                        acc       <= '0;
                        bit_cnt   <= '0;
                        ovf_int   <= 1'b0;
                    end
                end
                CONV: begin
                    shift_reg <= shift_reg << 1;
                    acc       <= acc_shift;
                    ovf_int   <= ovf_shift;
                    bit_cnt   <= bit_cnt + CW'(1);
                    if (last_shift) begin
                        bcd_out   <= result;
                        digit_cnt <= cnt_result;
                        ovf       <= ovf_shift;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_bcd_conv.sv
// Scoreboard bench for freq_bcd_conv: a 10-digit and a 4-digit instance checked against an arithmetic BCD model.
module tb_freq_bcd_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [29:0] bin_in = '0;
    logic        busy, done, ovf;
    logic [39:0] bcd_out;
    logic [3:0]  digit_cnt;
    logic        start4 = 1'b0;
    logic [29:0] bin_in4 = '0;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd_out4;
    logic [3:0]  digit_cnt4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int free10 = 0, free4 = 0, last10 = 0, last4 = 0;

    typedef struct {
        int          start_edge;
        logic [39:0] bcd;
        logic [3:0]  cnt;
        logic        ovf;
    } exp_t;

    exp_t q10[$];
    exp_t q4[$];

    freq_bcd_conv #(.BIN_WIDTH(30), .DIGITS(10)) dut (
        .sys_clk(clk), .sys_rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .digit_cnt(digit_cnt), .ovf(ovf)
    );

    freq_bcd_conv #(.BIN_WIDTH(30), .DIGITS(4)) dut4 (
        .sys_clk(clk), .sys_rst(rst), .start(start4), .bin_in(bin_in4),
        .busy(busy4), .done(done4), .bcd_out(bcd_out4), .digit_cnt(digit_cnt4), .ovf(ovf4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endfunction

    // Decimal digits by repeated division; saturate when the value needs more than nd digits
    function automatic void model(input longint unsigned v, input int nd,
                                  output logic [39:0] bcd, output logic [3:0] cnt, output logic o);
        longint unsigned lim;
        longint unsigned t;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        bcd = '0;
        cnt = 4'd1;
        o   = 1'b0;
        if (v >= lim) begin
            o   = 1'b1;
            cnt = 4'(nd);
            for (int i = 0; i < nd; i++) bcd[4*i +: 4] = 4'h9;
            return;
        end
        t = v;
        for (int i = 0; i < nd; i++) begin
            bcd[4*i +: 4] = 4'(t % 10);
            if (t % 10 != 0) cnt = 4'(i + 1);
            t = t / 10;
        end
`ifdef FREQ_BCD_LEADING_ZERO_BLANK_EN
        for (int i = 1; i < nd; i++) begin
            if (i >= int'(cnt)) bcd[4*i +: 4] = 4'hF;
        end
`endif
    endfunction

    // Must be called at a negedge; the request is sampled at the following posedge
    task automatic issue(input bit narrow, input logic [29:0] v);
        exp_t x;
        int   e;
        e = cyc + 1;
        x.start_edge = e;
        if (!narrow) begin
            start  = 1'b1;
            bin_in = v;
            if (e >= free10) begin
                model(64'(v), 10, x.bcd, x.cnt, x.ovf);
                q10.push_back(x);
                free10 = e + 32;
                last10 = e;
            end
        end else begin
            start4  = 1'b1;
            bin_in4 = v;
            if (e >= free4) begin
                model(64'(v), 4, x.bcd, x.cnt, x.ovf);
                q4.push_back(x);
                free4 = e + 32;
                last4 = e;
            end
        end
        @(negedge clk);
        start  = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((q10.size() != 0 || q4.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q10.size() != 0 || q4.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results still pending, required 0", q10.size() + q4.size());
            q10.delete();
            q4.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: done timing, busy window and result values against the queued expectations
    always @(negedge clk) begin
        bit   bexp, dexp;
        exp_t x;
        bexp = (q10.size() > 0) && cyc >= q10[0].start_edge && cyc <= q10[0].start_edge + 30;
        dexp = (q10.size() > 0) && cyc == q10[0].start_edge + 30;
        chk("busy10", 64'(busy), 64'(bexp));
        chk("done10", 64'(done), 64'(dexp));
        if (dexp) begin
            x = q10.pop_front();
            chk("bcd10", 64'(bcd_out), 64'(x.bcd));
            chk("cnt10", 64'(digit_cnt), 64'(x.cnt));
            chk("ovf10", 64'(ovf), 64'(x.ovf));
        end
        bexp = (q4.size() > 0) && cyc >= q4[0].start_edge && cyc <= q4[0].start_edge + 30;
        dexp = (q4.size() > 0) && cyc == q4[0].start_edge + 30;
        chk("busy4", 64'(busy4), 64'(bexp));
        chk("done4", 64'(done4), 64'(dexp));
        if (dexp) begin
            x = q4.pop_front();
            chk("bcd4", 64'(bcd_out4), 64'(x.bcd[15:0]));
            chk("cnt4", 64'(digit_cnt4), 64'(x.cnt));
            chk("ovf4", 64'(ovf4), 64'(x.ovf));
        end
    end

    initial begin
        int          w, gap;
        logic [29:0] v;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bcd", 64'(bcd_out), 64'd0);
        chk("rst_cnt", 64'(digit_cnt), 64'd1);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_cnt4", 64'(digit_cnt4), 64'd1);
        #2 rst = 1'b0;
        @(negedge clk);

        issue(1'b0, 30'd0);
        wait_idle(100);
        issue(1'b0, 30'd1073741823);
        wait_idle(100);
        issue(1'b0, 30'd999999999);
        wait_idle(100);

        // Back-to-back: a start in the done cycle is ignored, the next cycle is accepted
        issue(1'b0, 30'd50000000);
        while (cyc < last10 + 30) @(negedge clk);
        issue(1'b0, 30'd777);
        issue(1'b0, 30'd9);
        wait_idle(100);

        // Start while busy is dropped
        issue(1'b0, 30'd12345);
        while (cyc < last10 + 9) @(negedge clk);
        issue(1'b0, 30'd999);
        wait_idle(100);

        // Asynchronous reset in the middle of a conversion
        issue(1'b0, 30'd987654321);
        while (cyc < last10 + 15) @(negedge clk);
        #2 rst = 1'b1;
        q10.delete();
        free10 = 0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_bcd", 64'(bcd_out), 64'd0);
        chk("midrst_cnt", 64'(digit_cnt), 64'd1);
        chk("midrst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(1'b0, 30'd123456);
        wait_idle(100);

        // Four-digit instance: overflow, recovery and the 9999/10000 boundary
        issue(1'b1, 30'd12345);
        wait_idle(100);
        issue(1'b1, 30'd42);
        wait_idle(100);
        issue(1'b1, 30'd9999);
        wait_idle(100);
        issue(1'b1, 30'd10000);
        wait_idle(100);
        issue(1'b1, 30'd0);
        wait_idle(100);

        // Random values of random magnitude with random gaps, requests often landing while busy
        for (int i = 0; i < 30; i++) begin
            w = $urandom_range(30, 1);
            v = 30'($urandom) & ((30'd1 << w) - 30'd1);
            issue(1'b0, v);
            v = 30'($urandom_range(20000, 0));
            issue(1'b1, v);
            gap = $urandom_range(40, 0);
            repeat (gap) @(negedge clk);
        end
        wait_idle(200);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
